clock_mode_controller: RTL
==========================

// Module: clock_mode_controller
// PURPOSE
//  Control FSM for the digital clock. Decodes the debounced user buttons into mode selection (RUN / SET_TIME / SET_ALARM).
//  Issues single-cycle increment strobes to the time and alarm registers, with press-and-hold auto-repeat.
//  Owns alarm enable and the alarm beep/snooze sequencer. Sits between the button conditioning and the time/alarm datapath.
//  Drives the pm-independent status outputs (set_alarm_out, alarm_en_out, alarm_beep_out).
// PARAMETERS
//  SNOOZE_MIN    9  minutes in SNOOZE before the alarm re-sounds (1..15)
//  BEEP_MAX_MIN  5  minutes of unattended BEEP before auto-silence (1..15)
// PORTS
//  clk             in   1  system clock
//  reset           in   1  synchronous, active-low reset (0 = reset)
//  mode_cycle      in   1  debounced level; rising edge advances mode
//  set_fast        in   1  level; selects fast auto-repeat rate
//  set_hours       in   1  level; increment hours of selected register
//  set_minutes     in   1  level; increment minutes of selected register
//  snooze          in   1  level; rising edge snoozes a sounding alarm
//  alarm_reset     in   1  level; rising edge silences alarm or toggles alarm enable
//  tick_slow       in   1  1-cycle pulse, slow repeat rate (2 Hz)
//  tick_fast       in   1  1-cycle pulse, fast repeat rate (16 Hz)
//  tick_min        in   1  1-cycle pulse on every minute rollover of time
//  time_hours      in   5  current time hours, 0..23
//  time_minutes    in   6  current time minutes, 0..59
//  alarm_hours     in   5  alarm hours, 0..23
//  alarm_minutes   in   6  alarm minutes, 0..59
//  time_inc_hr     out  1  1-cycle strobe: time hours +1 (datapath wraps 23->0)
//  time_inc_min    out  1  1-cycle strobe: time minutes +1 (wraps 59->0, no hour carry)
//  alarm_inc_hr    out  1  1-cycle strobe: alarm hours +1
//  alarm_inc_min   out  1  1-cycle strobe: alarm minutes +1
//  time_hold       out  1  high in SET_TIME while set_hours|set_minutes held; datapath clears/holds seconds
//  set_alarm_out   out  1  high while mode==SET_ALARM
//  alarm_en_out    out  1  alarm armed
//  alarm_beep_out  out  1  alarm sounding
// BEHAVIOUR
//  - Reset (reset==0 at posedge): mode=RUN, alarm FSM=IDLE, all outputs 0, edge/prev-match regs 0, counters 0.
//  - All buttons registered once for edge detect. Rise = sampled 1 now, 0 previous cycle.
//    Every output is registered; response appears the cycle after the sampling edge.
//  - Mode FSM on mode_cycle rise: RUN->SET_TIME->SET_ALARM->RUN. Other inputs do not change mode.
//  - Increment (SET_TIME targets time_*, SET_ALARM targets alarm_*, RUN issues none):
//    set_x rise -> one strobe immediately.
//    While held -> one strobe per tick_fast if set_fast==1, else per tick_slow.
//    Rise and tick in the same cycle -> exactly one strobe.
//    hours and minutes both held -> hours only; minutes strobes suppressed until set_hours released.
//    Mode change while held: no strobe in the changing cycle; the new mode needs a fresh rise (held button ignored).
//  - Alarm match: match = (time_hours==alarm_hours && time_minutes==alarm_minutes); prev_match registered every cycle in all modes.
//    Trigger = match & ~prev_match & alarm_en & mode==RUN & FSM==IDLE.
//    Editing the alarm onto the current time and returning to RUN does not trigger.
//  - Alarm FSM: IDLE / BEEP / SNOOZE.
//    IDLE -> BEEP on trigger; beep_min cnt=0.
//    BEEP:   beep=1; tick_min increments cnt.
//            cnt==BEEP_MAX_MIN -> IDLE.
//            snooze rise -> SNOOZE, snz cnt=SNOOZE_MIN.
//            alarm_reset rise -> IDLE.
//    SNOOZE: beep=0; tick_min decrements snz; reaching 0 -> BEEP (cnt=0).
//            alarm_reset rise -> IDLE.
//    snooze and alarm_reset rise in same cycle: alarm_reset wins (IDLE).
//  - alarm_reset rise in IDLE toggles alarm_en_out. In BEEP/SNOOZE it only silences; enable is unchanged.
//    Clearing enable never occurs mid-alarm.
//  - Mode changes do not disturb the alarm FSM. Strobes are never issued from RUN.
//  - Reset asserted mid-operation: everything returns to reset values next cycle; held buttons need a fresh rise.
// CONFIGURATION
//  ALARM_CHIRP_EN defined: in BEEP, alarm_beep_out toggles on each tick_fast (starts 1 on BEEP entry).
//    Gives an 8 Hz chirp; forced 0 outside BEEP.
//  ALARM_CHIRP_EN undefined: alarm_beep_out is a steady 1 throughout BEEP.
// TESTING
//  1 reset=0 2 cycles, all inputs toggling -> every output 0, mode RUN; release reset -> still 0.
//  2 mode_cycle pulse x3 -> set_alarm_out 0,0,1,0 after pulses 0..3; SET_TIME, set_hours rise with set_fast=0, held for 4 tick_slow
//    -> exactly 5 time_inc_hr strobes, time_hold=1 throughout, 0 alarm_inc_*.
//  3 SET_ALARM, set_minutes+set_fast held for 10 tick_fast, set_hours asserted after 5
//    -> 6 alarm_inc_min then alarm_inc_hr only.
//  4 alarm 07:00, alarm_en=1 (one alarm_reset rise), time steps 06:59->07:00 in RUN -> alarm_beep_out=1 next cycle;
//    5 tick_min pulses -> beep 0, FSM IDLE, alarm_en still 1.
//  5 while BEEP, snooze rise -> beep 0; 9 tick_min -> beep 1; alarm_reset rise -> beep 0, alarm_en_out unchanged 1.
//  6 with ALARM_CHIRP_EN: BEEP entry -> beep 1, toggles on each tick_fast; set alarm==time in SET_ALARM, return to RUN -> no beep.

Source files
------------

// File: rtl/clock_mode_controller.sv
// clock_mode_controller
//
// Purpose:
//   Control FSM for the digital clock. Decodes debounced user buttons into
//   the RUN / SET_TIME / SET_ALARM modes, issues single-cycle increment
//   strobes (with press-and-hold auto-repeat) to the time and alarm
//   registers, and owns the alarm enable plus the beep/snooze sequencer.
//
// Parameters:
//   SNOOZE_MIN    minutes spent in SNOOZE before the alarm re-sounds (1..15)
//   BEEP_MAX_MIN  minutes of unattended BEEP before auto-silence (1..15)
//
// Configuration macro:
//   ALARM_CHIRP_EN  when defined, alarm_beep_o toggles on every tick_fast_i
//                   while beeping (8 Hz chirp); otherwise it is a steady 1.
//
// Ports:
//   clk_i              system clock
//   reset_i            synchronous active-low reset (0 = reset)
//   mode_cycle_i       rising edge advances RUN -> SET_TIME -> SET_ALARM -> RUN
//   set_fast_i         selects the fast auto-repeat rate
//   set_hours_i        increment hours of the selected register
//   set_minutes_i      increment minutes of the selected register
//   snooze_i           rising edge snoozes a sounding alarm
//   alarm_reset_i      rising edge silences the alarm or toggles the enable
//   tick_slow_i        1-cycle slow repeat pulse (2 Hz)
//   tick_fast_i        1-cycle fast repeat pulse (16 Hz)
//   tick_min_i         1-cycle pulse on every minute rollover
//   time_hours_i       current hours, 0..23
//   time_minutes_i     current minutes, 0..59
//   alarm_hours_i      alarm hours, 0..23
//   alarm_minutes_i    alarm minutes, 0..59
//   time_inc_hr_o      strobe: time hours +1
//   time_inc_min_o     strobe: time minutes +1
//   alarm_inc_hr_o     strobe: alarm hours +1
//   alarm_inc_min_o    strobe: alarm minutes +1
//   time_hold_o        SET_TIME with a set button held; datapath holds seconds
//   set_alarm_o        high while in SET_ALARM
//   alarm_en_o         alarm armed
//   alarm_beep_o       alarm sounding
module clock_mode_controller #(
  parameter int unsigned SNOOZE_MIN   = 9,
  parameter int unsigned BEEP_MAX_MIN = 5
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       mode_cycle_i,
  input  logic       set_fast_i,
  input  logic       set_hours_i,
  input  logic       set_minutes_i,
  input  logic       snooze_i,
  input  logic       alarm_reset_i,
  input  logic       tick_slow_i,
  input  logic       tick_fast_i,
  input  logic       tick_min_i,
  input  logic [4:0] time_hours_i,
  input  logic [5:0] time_minutes_i,
  input  logic [4:0] alarm_hours_i,
  input  logic [5:0] alarm_minutes_i,
  output logic       time_inc_hr_o,
  output logic       time_inc_min_o,
  output logic       alarm_inc_hr_o,
  output logic       alarm_inc_min_o,
  output logic       time_hold_o,
  output logic       set_alarm_o,
  output logic       alarm_en_o,
  output logic       alarm_beep_o
);

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } modeE;

  typedef enum logic [1:0] {
    ALARM_IDLE   = 2'd0,
    ALARM_BEEP   = 2'd1,
    ALARM_SNOOZE = 2'd2
  } alarmE;

  localparam logic [3:0] SnoozeLoad = 4'(SNOOZE_MIN);
  localparam logic [3:0] BeepLimit  = 4'(BEEP_MAX_MIN);

  modeE       mode_q, mode_d;
  alarmE      alarmState_q, alarmState_d;
  logic       modeCyclePrev_q, setHoursPrev_q, setMinutesPrev_q;
  logic       snoozePrev_q, alarmResetPrev_q, prevMatch_q;
  logic       hrArmed_q, hrArmed_d, minArmed_q, minArmed_d;
  logic [3:0] beepCnt_q, beepCnt_d, snzCnt_q, snzCnt_d;
  logic       alarmEn_q, alarmEn_d, beep_q, beep_d;
  logic       timeIncHr_q, timeIncHr_d, timeIncMin_q, timeIncMin_d;
  logic       alarmIncHr_q, alarmIncHr_d, alarmIncMin_q, alarmIncMin_d;
  logic       timeHold_q, timeHold_d, setAlarm_q, setAlarm_d;

  logic modeRise, hoursRise, minutesRise, snoozeRise, alarmResetRise;
  logic repeatTick, inSetMode, hrStrobe, minStrobe, match, trigger;

  assign modeRise       = mode_cycle_i & ~modeCyclePrev_q;
  assign hoursRise      = set_hours_i & ~setHoursPrev_q;
  assign minutesRise    = set_minutes_i & ~setMinutesPrev_q;
  assign snoozeRise     = snooze_i & ~snoozePrev_q;
  assign alarmResetRise = alarm_reset_i & ~alarmResetPrev_q;

  assign match      = (time_hours_i == alarm_hours_i) && (time_minutes_i == alarm_minutes_i);
  assign repeatTick = set_fast_i ? tick_fast_i : tick_slow_i;
  assign inSetMode  = (mode_q != MODE_RUN);

  // A held button only repeats once its own rise was seen in the current
  // mode (armed flag), so a button carried across a mode change stays inert.
  // Hours take priority: minutes are muted while set_hours_i is held.
  assign hrStrobe  = inSetMode & ~modeRise &
                     (hoursRise | (set_hours_i & hrArmed_q & repeatTick));
  assign minStrobe = inSetMode & ~modeRise & ~set_hours_i &
                     (minutesRise | (set_minutes_i & minArmed_q & repeatTick));

  // An alarm_reset rise in IDLE is reserved for toggling the enable, so it
  // blocks a same-cycle trigger; this keeps the enable stable mid-alarm.
  assign trigger = match & ~prevMatch_q & alarmEn_q & (mode_q == MODE_RUN) &
                   (alarmState_q == ALARM_IDLE) & ~alarmResetRise;

  // Mode sequencing and auto-repeat arming.
  always_comb begin
    mode_d     = mode_q;
    hrArmed_d  = inSetMode & ~modeRise & set_hours_i & (hoursRise | hrArmed_q);
    minArmed_d = inSetMode & ~modeRise & set_minutes_i & (minutesRise | minArmed_q);
    if (modeRise) begin
      case (mode_q)
        MODE_RUN:      mode_d = MODE_SET_TIME;
        MODE_SET_TIME: mode_d = MODE_SET_ALARM;
        default:       mode_d = MODE_RUN;
      endcase
    end
  end

  // Alarm sequencer. alarm_reset has priority over snooze in every state.
  always_comb begin
    alarmState_d = alarmState_q;
    beepCnt_d    = beepCnt_q;
    snzCnt_d     = snzCnt_q;
    alarmEn_d    = alarmEn_q;
    case (alarmState_q)
      ALARM_IDLE: begin
        if (alarmResetRise) begin
          alarmEn_d = ~alarmEn_q;
        end else if (trigger) begin
          alarmState_d = ALARM_BEEP;
          beepCnt_d    = 4'd0;
        end
      end
      ALARM_BEEP: begin
        if (alarmResetRise) begin
          alarmState_d = ALARM_IDLE;
        end else if (snoozeRise) begin
          alarmState_d = ALARM_SNOOZE;
          snzCnt_d     = SnoozeLoad;
        end else if (tick_min_i) begin
          if (beepCnt_q + 4'd1 == BeepLimit) begin
            alarmState_d = ALARM_IDLE;
            beepCnt_d    = 4'd0;
          end else begin
            beepCnt_d = beepCnt_q + 4'd1;
          end
        end
      end
      ALARM_SNOOZE: begin
        if (alarmResetRise) begin
          alarmState_d = ALARM_IDLE;
        end else if (tick_min_i) begin
          if (snzCnt_q <= 4'd1) begin
            alarmState_d = ALARM_BEEP;
            beepCnt_d    = 4'd0;
            snzCnt_d     = 4'd0;
          end else begin
            snzCnt_d = snzCnt_q - 4'd1;
          end
        end
      end
      default: alarmState_d = ALARM_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    timeIncHr_d   = hrStrobe & (mode_q == MODE_SET_TIME);
    timeIncMin_d  = minStrobe & (mode_q == MODE_SET_TIME);
    alarmIncHr_d  = hrStrobe & (mode_q == MODE_SET_ALARM);
    alarmIncMin_d = minStrobe & (mode_q == MODE_SET_ALARM);
    timeHold_d    = (mode_q == MODE_SET_TIME) & (set_hours_i | set_minutes_i);
    setAlarm_d    = (mode_d == MODE_SET_ALARM);
`ifdef ALARM_CHIRP_EN
    // Chirp starts high on every BEEP entry, then flips on each fast tick.
    if (alarmState_d != ALARM_BEEP) begin
      beep_d = 1'b0;
    end else if (alarmState_q != ALARM_BEEP) begin
      beep_d = 1'b1;
    end else if (tick_fast_i) begin
      beep_d = ~beep_q;
    end else begin
      beep_d = beep_q;
    end
`else
    beep_d = (alarmState_d == ALARM_BEEP);
`endif
  end

  // All state and outputs update together on the clock edge.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      mode_q           <= MODE_RUN;
      alarmState_q     <= ALARM_IDLE;
      modeCyclePrev_q  <= 1'b0;
      setHoursPrev_q   <= 1'b0;
      setMinutesPrev_q <= 1'b0;
      snoozePrev_q     <= 1'b0;
      alarmResetPrev_q <= 1'b0;
      prevMatch_q      <= 1'b0;
      hrArmed_q        <= 1'b0;
      minArmed_q       <= 1'b0;
      beepCnt_q        <= 4'd0;
      snzCnt_q         <= 4'd0;
      alarmEn_q        <= 1'b0;
      beep_q           <= 1'b0;
      timeIncHr_q      <= 1'b0;
      timeIncMin_q     <= 1'b0;
      alarmIncHr_q     <= 1'b0;
      alarmIncMin_q    <= 1'b0;
      timeHold_q       <= 1'b0;
      setAlarm_q       <= 1'b0;
    end else begin
      mode_q           <= mode_d;
      alarmState_q     <= alarmState_d;
      modeCyclePrev_q  <= mode_cycle_i;
      setHoursPrev_q   <= set_hours_i;
      setMinutesPrev_q <= set_minutes_i;
      snoozePrev_q     <= snooze_i;
      alarmResetPrev_q <= alarm_reset_i;
      prevMatch_q      <= match;
      hrArmed_q        <= hrArmed_d;
      minArmed_q       <= minArmed_d;
      beepCnt_q        <= beepCnt_d;
      snzCnt_q         <= snzCnt_d;
      alarmEn_q        <= alarmEn_d;
      beep_q           <= beep_d;
      timeIncHr_q      <= timeIncHr_d;
      timeIncMin_q     <= timeIncMin_d;
      alarmIncHr_q     <= alarmIncHr_d;
      alarmIncMin_q    <= alarmIncMin_d;
      timeHold_q       <= timeHold_d;
      setAlarm_q       <= setAlarm_d;
    end
  end

  assign time_inc_hr_o   = timeIncHr_q;
  assign time_inc_min_o  = timeIncMin_q;
  assign alarm_inc_hr_o  = alarmIncHr_q;
  assign alarm_inc_min_o = alarmIncMin_q;
  assign time_hold_o     = timeHold_q;
  assign set_alarm_o     = setAlarm_q;
  assign alarm_en_o      = alarmEn_q;
  assign alarm_beep_o    = beep_q;

endmodule
